if_stage: RTL
=============

# if_stage

Instruction-fetch stage of the dual-issue VLIW pipeline. It is the producer side of the IF/ID interface: it owns the PC and fetches one 32-bit bundle (ALU slot plus MEM slot) per cycle from instruction memory. It presents the bundle to the decode stage through the IF/ID pipeline register and acts on the decode stage's `pcSrc`, `IF_flush`, stall and branch/jump offsets. It also takes EX-stage undefined-instruction exceptions through a small run/handler/halt state machine.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value after reset.
- `EXC_VECTOR`, 32'h0000_0040, handler entry address.
- `NOP`, 16'h0000, instruction word injected on flush.

Ports:
- `clk`  in  1  pipeline clock.
- `reset`  in  1  asynchronous, active-high.
- `p1_pipeline_regWrite`  in  1  IF/ID and PC write enable; 0 = stall.
- `IF_flush`  in  1  replace the next IF/ID contents with a bubble.
- `pcSrc`  in  2  next-PC select: 00 = seq, 01 = branch, 10 = jump, 11 = trap.
- `mem_shiftedSext8_branchOffset`  in  32  branch byte offset, relative to `p1_pc`.
- `mem_shiftedSext11_jumpOffset`  in  32  jump byte offset, relative to `p1_pc`.
- `p2_alu_undefinedInstruction`, `p2_mem_undefinedInstruction`  in  1 each  EX-stage exceptions.
- `p2_pc`  in  32  PC of the bundle in EX; captured as EPC.
- `eret`  in  1  return from handler.
- `imem_addr`  out  32  fetch address (= `pc`).
- `imem_rdata`  in  32  combinational bundle: [15:0] ALU instruction, [31:16] MEM instruction.
- `p1_aluInstr`, `p1_memInstr`  out  16 each  IF/ID instruction words.
- `p1_pc`  out  32  address of the bundle in IF/ID.
- `p1_valid`  out  1  IF/ID holds a real bundle.
- `pc`  out  32  current PC.
- `epc`  out  32  exception PC.
- `excCause`  out  2  00 = none, 01 = undefined ALU, 10 = undefined MEM, 11 = trap.
- `halted`  out  1  core frozen after a nested exception.

## Operation
- Reset values:
  - `pc` = `RESET_PC`.
  - `p1_aluInstr` = `p1_memInstr` = `NOP`.
  - `p1_pc` = 0, `p1_valid` = 0.
  - `epc` = 0, `excCause` = 00, `halted` = 0, state = RUN.
- States:
  - RUN: normal fetch.
  - HANDLER: executing the exception handler.
  - HALTED: PC and IF/ID frozen, `halted` = 1; leave only by reset.
- Exception event: either `p2_*_undefinedInstruction` = 1, or `pcSrc` = 11.
  - `excCause` records it; priority is ALU > MEM > trap.
  - For a trap, `epc` takes `p1_pc`; for an undefined instruction, `epc` takes `p2_pc`.
- Next-PC priority, highest first:
  1. State HALTED: hold everything.
  2. Exception event in RUN: `pc` ← `EXC_VECTOR`, capture `epc`/`excCause`, IF/ID ← bubble, go to HANDLER.
  3. Exception event in HANDLER: go to HALTED, `pc` unchanged.
  4. `eret` in HANDLER: `pc` ← `epc`+4, IF/ID ← bubble, `excCause` ← 00, go to RUN. `eret` in RUN is ignored.
  5. `pcSrc` 01: `pc` ← `p1_pc` + branchOffset. `pcSrc` 10: `pc` ← `p1_pc` + jumpOffset. Both apply even when stalled.
  6. `p1_pipeline_regWrite` = 0: `pc` holds.
  7. Otherwise `pc` ← `pc` + 4.
- Width and arithmetic rules:
  - All PC arithmetic is modulo 2^32; wrap-around is silent.
  - Computed targets have bits [1:0] forced to 00, truncating halfword offsets.
- IF/ID register update:
  - Bubble = (`NOP`, `NOP`, `p1_valid` = 0, `p1_pc` unchanged).
  - Bubble is loaded on `IF_flush`, on any redirect, or on an exception. Flush wins over stall.
  - Else, when `p1_pipeline_regWrite` = 1: load `imem_rdata` slots, `p1_pc` ← `pc`, `p1_valid` ← 1.
  - Else hold.

## Timing
- Single clock. All state updates on the rising edge of `clk`; `reset` is asynchronous.
- `imem_addr` is combinational from `pc`.
- The bundle at `pc` enters IF/ID at the next edge; fetch latency is 1 cycle.
- Redirect latency: `pcSrc` or exception sampled at edge N gives `pc` = target after edge N. The target bundle is in IF/ID after edge N+1, with exactly one bubble in between.
- A stall of k cycles holds `pc` and IF/ID for k edges with no duplicated or lost bundle.
- Reset asserted mid-operation forces all reset values immediately, regardless of state.

## Structure
- Shared package `vliw_pkg` holds:
  - `pcSrc` codes (PCSRC_SEQ/BRANCH/JUMP/TRAP).
  - `excCause` codes.
  - State enum {RUN, HANDLER, HALTED}.
  - `NOP` constant.
- Sub-module `pipeline_IF_ID` holds the register with write-enable and flush, mirroring `pipeline_ID_EX`.
- Next-PC mux, exception capture and FSM live in the top module.

## Test plan
- Reset, then 3 unstalled cycles with `imem_rdata` = {addr[15:0], addr[15:0]} → `p1_pc` = 0, 4, 8; `pc` = 12; `p1_valid` = 1 from the first edge.
- `p1_pipeline_regWrite` = 0 for 2 cycles at `pc` = 8 → `pc` stays 8 and IF/ID holds bundle 4; on resume `p1_pc` = 8.
- `p1_pc` = 0x20, `pcSrc` = 01, branchOffset = 0xFFFF_FFF0 → `pc` = 0x10, one bubble, then `p1_pc` = 0x10. Same with offset 0x6 → `pc` = 0x24.
- `p2_mem_undefinedInstruction` = 1 with `p2_pc` = 0x30 → `pc` = 0x40, `epc` = 0x30, `excCause` = 10, state HANDLER; `eret` → `pc` = 0x34, `excCause` = 00.
- In HANDLER, `pcSrc` = 11 → `halted` = 1 and `pc` frozen for 10 cycles; async `reset` pulse mid-cycle → `pc` = 0, `halted` = 0.
- `pc` = 0xFFFF_FFFC, no stall → next `pc` = 0x0000_0000.

Source files
------------

// File: rtl/vliw_pkg.sv
// Shared definitions for the dual-issue VLIW pipeline: next-PC select codes,
// exception cause codes, fetch-stage FSM states and the bubble instruction word.
package vliw_pkg;

  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_TRAP   = 2'b11;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_UNDEF_ALU = 2'b01;
  localparam logic [1:0] EXC_UNDEF_MEM = 2'b10;
  localparam logic [1:0] EXC_TRAP     = 2'b11;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    RUN,
    HANDLER,
    HALTED
  } ifState_e;

  // Computed fetch targets are word aligned; halfword offsets are truncated.
  function automatic logic [31:0] alignPc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pipeline_IF_ID.sv
// IF/ID pipeline register: write enable for stalls, flush inserts a bubble that
// keeps the previous bundle address. Flush takes precedence over a stall.
module pipeline_IF_ID
  import vliw_pkg::*;
#(
  parameter logic [15:0] NOP = NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        regWrite,
  input  logic        flush,
  input  logic [15:0] aluInstrIn,
  input  logic [15:0] memInstrIn,
  input  logic [31:0] pcIn,
  output logic [15:0] aluInstr,
  output logic [15:0] memInstr,
  output logic [31:0] pcOut,
  output logic        valid
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aluInstr <= NOP;
      memInstr <= NOP;
      pcOut    <= 32'h0000_0000;
      valid    <= 1'b0;
    end else if (flush) begin
      aluInstr <= NOP;
      memInstr <= NOP;
      valid    <= 1'b0;
    end else if (regWrite) begin
      aluInstr <= aluInstrIn;
      memInstr <= memInstrIn;
      pcOut    <= pcIn;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, feeds the IF/ID register and handles
// undefined-instruction / trap exceptions through a RUN/HANDLER/HALTED FSM.
module if_stage
  import vliw_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0040,
  parameter logic [15:0] NOP        = NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p1_pipeline_regWrite,
  input  logic        IF_flush,
  input  logic [1:0]  pcSrc,
  input  logic [31:0] mem_shiftedSext8_branchOffset,
  input  logic [31:0] mem_shiftedSext11_jumpOffset,
  input  logic        p2_alu_undefinedInstruction,
  input  logic        p2_mem_undefinedInstruction,
  input  logic [31:0] p2_pc,
  input  logic        eret,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [15:0] p1_aluInstr,
  output logic [15:0] p1_memInstr,
  output logic [31:0] p1_pc,
  output logic        p1_valid,
  output logic [31:0] pc,
  output logic [31:0] epc,
  output logic [1:0]  excCause,
  output logic        halted
);

  ifState_e    state;
  logic        frozen;
  logic        undefEvent;
  logic        excEvent;
  logic        doEret;
  logic        isBranch;
  logic        isJump;
  logic        redirect;
  logic        ifidFlush;
  logic        ifidWrite;
  logic [1:0]  causeNext;
  logic [31:0] epcNext;
  logic [31:0] branchTarget;
  logic [31:0] jumpTarget;
  logic [31:0] pcNext;

  assign imem_addr = pc;

  assign frozen     = (state == HALTED);
  assign undefEvent = p2_alu_undefinedInstruction | p2_mem_undefinedInstruction;
  assign excEvent   = !frozen && (undefEvent || (pcSrc == PCSRC_TRAP));
  assign doEret     = (state == HANDLER) && eret && !excEvent;
  assign isBranch   = (pcSrc == PCSRC_BRANCH);
  assign isJump     = (pcSrc == PCSRC_JUMP);
  assign redirect   = !frozen && !excEvent && !doEret && (isBranch || isJump);

  assign branchTarget = alignPc(p1_pc + mem_shiftedSext8_branchOffset);
  assign jumpTarget   = alignPc(p1_pc + mem_shiftedSext11_jumpOffset);

  // Cause priority: ALU slot, then MEM slot, then trap.
  always_comb begin
    causeNext = EXC_TRAP;
    epcNext   = p1_pc;
    if (p2_alu_undefinedInstruction) begin
      causeNext = EXC_UNDEF_ALU;
      epcNext   = p2_pc;
    end else if (p2_mem_undefinedInstruction) begin
      causeNext = EXC_UNDEF_MEM;
      epcNext   = p2_pc;
    end
  end

  always_comb begin
    pcNext = pc;
    if (frozen) begin
      pcNext = pc;
    end else if (excEvent) begin
      // A nested exception leaves the PC where it is and freezes the core.
      pcNext = (state == RUN) ? EXC_VECTOR : pc;
    end else if (doEret) begin
      pcNext = alignPc(epc + 32'd4);
    end else if (isBranch) begin
      pcNext = branchTarget;
    end else if (isJump) begin
      pcNext = jumpTarget;
    end else if (p1_pipeline_regWrite) begin
      pcNext = alignPc(pc + 32'd4);
    end
  end

  assign ifidFlush = !frozen && (IF_flush || excEvent || doEret || redirect);
  assign ifidWrite = !frozen && p1_pipeline_regWrite;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      pc       <= RESET_PC;
      epc      <= 32'h0000_0000;
      excCause <= EXC_NONE;
      halted   <= 1'b0;
    end else begin
      pc <= pcNext;
      case (state)
        RUN: begin
          if (excEvent) begin
            epc      <= epcNext;
            excCause <= causeNext;
            state    <= HANDLER;
          end
        end
        HANDLER: begin
          if (excEvent) begin
            halted <= 1'b1;
            state  <= HALTED;
          end else if (eret) begin
            excCause <= EXC_NONE;
            state    <= RUN;
          end
        end
        HALTED: begin
          halted <= 1'b1;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  pipeline_IF_ID #(
    .NOP(NOP)
  ) u_pipeline_IF_ID (
    .clk       (clk),
    .reset     (reset),
    .regWrite  (ifidWrite),
    .flush     (ifidFlush),
    .aluInstrIn(imem_rdata[15:0]),
    .memInstrIn(imem_rdata[31:16]),
    .pcIn      (pc),
    .aluInstr  (p1_aluInstr),
    .memInstr  (p1_memInstr),
    .pcOut     (p1_pc),
    .valid     (p1_valid)
  );

endmodule
